// File: rtl/i2c_master_pkg.sv
// Shared types and default bus timing for the single-byte I2C master.
// The bit period is split into four equal quarters that pace SCL and SDA.
package i2c_master_pkg;

    localparam int unsigned DEFAULT_SYS_FREQ = 50_000_000;
    localparam int unsigned DEFAULT_I2C_FREQ = 100_000;
    localparam int unsigned CLKS_PER_BIT     = DEFAULT_SYS_FREQ / DEFAULT_I2C_FREQ;
    localparam int unsigned QUARTER_CLKS     = CLKS_PER_BIT / 4;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        MST_NACK,
        STOP,
        DONE
    } state_e;

endpackage

// File: rtl/i2c_bit_timer.sv
// Free-running bit-period counter for the I2C master: reports the current
// quarter, a mid-SCL-high sample strobe and an end-of-bit strobe.
module i2c_bit_timer
    import i2c_master_pkg::*;
#(
    parameter int unsigned BIT_CLKS = CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    output logic [1:0] quarter_o,
    output logic       sample_o,
    output logic       bitEnd_o
);

    localparam int unsigned QLEN = BIT_CLKS / 4;
    localparam int unsigned CW   = $clog2(BIT_CLKS);

    localparam logic [CW-1:0] LAST      = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] Q1_START  = CW'(QLEN);
    localparam logic [CW-1:0] Q2_START  = CW'(2 * QLEN);
    localparam logic [CW-1:0] Q3_START  = CW'(3 * QLEN);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(3 * QLEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is held at zero while idle so every transaction starts on a clean bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Any remainder of BIT_CLKS/4 is absorbed by the last quarter.
    always_comb begin
        if (cnt_q < Q1_START) begin
            quarter_o = 2'd0;
        end else if (cnt_q < Q2_START) begin
            quarter_o = 2'd1;
        end else if (cnt_q < Q3_START) begin
            quarter_o = 2'd2;
        end else begin
            quarter_o = 2'd3;
        end
    end

    assign sample_o = run_i && (cnt_q == SAMPLE_AT);
    assign bitEnd_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte written or read
// (read ends with a master NACK), then STOP. SCL and SDA are open-drain.
module i2c_master
    import i2c_master_pkg::*;
#(
    parameter int unsigned SYS_FREQ = DEFAULT_SYS_FREQ,
    parameter int unsigned I2C_FREQ = DEFAULT_I2C_FREQ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic       dataValid,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ackErr,
    output logic       done,
    inout  wire        sda,
    inout  wire        scl
);

    localparam int unsigned BIT_CLKS = SYS_FREQ / I2C_FREQ;

    state_e     state_q, state_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       rw_q, rw_d;
    logic       ackBit_q, ackBit_d;
    logic       ackErr_q, ackErr_d;
    logic [7:0] dout_q, dout_d;

    logic       run;
    logic [1:0] quarter;
    logic       sampleTick;
    logic       bitEnd;
    logic       sclLow;
    logic       sdaLow;
    logic       sdaIn;

    assign run   = (state_q != IDLE) && (state_q != DONE);
    assign sdaIn = sda;

    i2c_bit_timer #(
        .BIT_CLKS(BIT_CLKS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run_i    (run),
        .quarter_o(quarter),
        .sample_o (sampleTick),
        .bitEnd_o (bitEnd)
    );

    // Next state, shifters and the two open-drain pull-down enables.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        rw_d     = rw_q;
        ackBit_d = ackBit_q;
        ackErr_d = ackErr_q;
        dout_d   = dout_q;
        sclLow   = 1'b0;
        sdaLow   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dataValid) begin
                    shift_d  = {addr, rw};
                    data_d   = din;
                    rw_d     = rw;
                    ackErr_d = 1'b0;
                    bitCnt_d = 3'd0;
                    state_d  = START;
                end
            end
            START: begin
                // SDA drops in Q1 with SCL still high, then SCL is pulled low.
                sdaLow = (quarter != 2'd0);
                sclLow = quarter[1];
                if (bitEnd) begin
                    state_d = ADDR;
                end
            end
            ADDR, WR_DATA: begin
                sclLow = !quarter[1];
                sdaLow = !shift_q[7];
                if (bitEnd) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
                    end
                end
            end
            ADDR_ACK: begin
                sclLow = !quarter[1];
                if (sampleTick) begin
                    ackBit_d = sdaIn;
                end
                if (bitEnd) begin
                    if (ackBit_q) begin
                        ackErr_d = 1'b1;
                        state_d  = STOP;
                    end else if (rw_q) begin
                        state_d = RD_DATA;
                    end else begin
                        shift_d = data_q;
                        state_d = WR_DATA;
                    end
                end
            end
            WR_ACK: begin
                sclLow = !quarter[1];
                if (sampleTick) begin
                    ackBit_d = sdaIn;
                end
                if (bitEnd) begin
                    ackErr_d = ackErr_q | ackBit_q;
                    state_d  = STOP;
                end
            end
            RD_DATA: begin
                sclLow = !quarter[1];
                if (sampleTick) begin
                    shift_d = {shift_q[6:0], sdaIn};
                end
                if (bitEnd) begin
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = MST_NACK;
                    end
                end
            end
            MST_NACK: begin
                sclLow = !quarter[1];
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // SDA is let go only in Q3, after SCL has been high for a quarter.
                sclLow = !quarter[1];
                sdaLow = (quarter != 2'd3);
                if (bitEnd) begin
                    if (rw_q && !ackErr_q) begin
                        dout_d = shift_q;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            bitCnt_q <= 3'd0;
            shift_q  <= 8'h00;
            data_q   <= 8'h00;
            rw_q     <= 1'b0;
            ackBit_q <= 1'b0;
            ackErr_q <= 1'b0;
            dout_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            rw_q     <= rw_d;
            ackBit_q <= ackBit_d;
            ackErr_q <= ackErr_d;
            dout_q   <= dout_d;
        end
    end

    assign scl    = sclLow ? 1'b0 : 1'bz;
    assign sda    = sdaLow ? 1'b0 : 1'bz;
    assign busy   = run;
    assign done   = (state_q == DONE);
    assign ackErr = ackErr_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: a behavioural I2C slave on the bus plus a
// scoreboard of expected per-transaction results.
module tb_i2c_master;

    localparam int CLK_PERIOD = 10;
    localparam int BIT_CLKS   = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rw = 1'b0;
    logic       dataValid = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] din = 8'h00;
    wire  [7:0] dout;
    wire        busy;
    wire        ackErr;
    wire        done;
    wire        sda;
    wire        scl;

    pullup (sda);
    pullup (scl);

    logic slaveLow = 1'b0;
    assign sda = slaveLow ? 1'b0 : 1'bz;

    i2c_master dut (
        .clk      (clk),
        .rst      (rst),
        .rw       (rw),
        .dataValid(dataValid),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .ackErr   (ackErr),
        .done     (done),
        .sda      (sda),
        .scl      (scl)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    typedef struct {
        logic [7:0] addrByte;
        logic [7:0] dataByte;
        int         bytes;
        logic       ackErr;
        logic [7:0] dout;
        int         cycles;
        logic       isRead;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic       addrAckEn = 1'b1;
    logic       dataAckEn = 1'b1;
    logic [7:0] readData = 8'h00;

    logic       inXfer = 1'b0;
    int         bitIdx = 0;
    int         byteIdx = 0;
    logic [7:0] shiftIn = 8'h00;
    logic       rwBit = 1'b0;
    logic       addrAcked = 1'b0;
    logic [7:0] capAddr = 8'h00;
    logic [7:0] capData = 8'h00;
    int         capBytes = 0;
    logic       masterNack = 1'b0;
    logic       stopSeen = 1'b0;
    time        dataRiseTime = 0;
    time        acceptTime = 0;
    time        lastRise = 0;
    logic       lastRiseValid = 1'b0;
    time        minGap = 64'hFFFF_FFFF;

    // Behavioural slave: follows START/STOP and SCL edges, ACKs per configuration
    // and serves readData on a read.
    initial begin
        logic sclPrev, sdaPrev, sclNow, sdaNow;
        sclPrev = 1'b1;
        sdaPrev = 1'b1;
        forever begin
            @(negedge clk);
            sclNow = (scl === 1'b1);
            sdaNow = (sda === 1'b1);
            if (!sclPrev && sclNow) begin
                if (lastRiseValid && ($time - lastRise) < minGap) minGap = $time - lastRise;
                lastRise = $time;
                lastRiseValid = 1'b1;
            end
            if (sclPrev && sclNow && sdaPrev && !sdaNow) begin
                inXfer = 1'b1; bitIdx = 0; byteIdx = 0; capBytes = 0;
                stopSeen = 1'b0; masterNack = 1'b0; addrAcked = 1'b0; slaveLow = 1'b0;
            end else if (inXfer && sclPrev && sclNow && !sdaPrev && sdaNow) begin
                stopSeen = 1'b1; inXfer = 1'b0; slaveLow = 1'b0;
            end else if (inXfer && !sclPrev && sclNow) begin
                if (bitIdx < 8) begin
                    shiftIn = {shiftIn[6:0], sdaNow};
                    if (byteIdx == 1 && bitIdx == 0) dataRiseTime = $time;
                end else if (byteIdx == 1 && rwBit) begin
                    masterNack = sdaNow;
                end
                bitIdx++;
            end else if (inXfer && sclPrev && !sclNow) begin
                if (bitIdx == 8) begin
                    capBytes++;
                    if (byteIdx == 0) begin
                        capAddr = shiftIn; rwBit = shiftIn[0];
                        addrAcked = addrAckEn; slaveLow = addrAckEn;
                    end else begin
                        capData = shiftIn; slaveLow = !rwBit && dataAckEn;
                    end
                end else if (bitIdx == 9) begin
                    bitIdx = 0; byteIdx++;
                    slaveLow = rwBit && addrAcked && byteIdx == 1 && !readData[7];
                end else if (rwBit && addrAcked && byteIdx == 1) begin
                    slaveLow = !readData[7 - bitIdx];
                end
            end
            sclPrev = sclNow;
            sdaPrev = sdaNow;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pushExpected(input logic [7:0] aByte, input logic [7:0] dByte, input int nBytes,
                                input logic eAckErr, input logic [7:0] eDout, input int eCycles,
                                input logic eRead);
        exp_t e;
        e.addrByte = aByte; e.dataByte = dByte; e.bytes = nBytes; e.ackErr = eAckErr;
        e.dout = eDout; e.cycles = eCycles; e.isRead = eRead;
        sb.push_back(e);
    endtask

    // Requests one transaction, waits (bounded) for done and scores it against the queue head.
    task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] d,
                                 input logic aAck, input logic dAck, input logic [7:0] rdByte,
                                 input logic hold);
        int   n;
        int   cycles;
        exp_t e;
        addrAckEn = aAck; dataAckEn = dAck; readData = rdByte;
        addr = a; rw = r; din = d; dataValid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 10);
        checkOutput("acceptBusy", 32'(busy), 32'd1);
        checkOutput("acceptAckErrClear", 32'(ackErr), 32'd0);
        acceptTime = $time;
        if (!hold) begin
            dataValid = 1'b0; addr = ~a; din = ~d; rw = ~r;
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 12000) begin
            @(negedge clk);
            cycles++;
        end
        e = sb.pop_front();
        checkOutput("doneSeen", 32'(done), 32'd1);
        checkOutput("doneCycle", 32'(cycles), 32'(e.cycles));
        checkOutput("busyAtDone", 32'(busy), 32'd0);
        checkOutput("ackErrAtDone", 32'(ackErr), 32'(e.ackErr));
        checkOutput("doutAtDone", 32'(dout), 32'(e.dout));
        checkOutput("busAddrByte", 32'(capAddr), 32'(e.addrByte));
        checkOutput("busByteCount", 32'(capBytes), 32'(e.bytes));
        checkOutput("busStop", 32'(stopSeen), 32'd1);
        if (e.bytes == 2) begin
            checkOutput("busDataByte", 32'(capData), 32'(e.dataByte));
            checkOutput("dataPhaseStart", 32'((dataRiseTime - acceptTime) / CLK_PERIOD),
                        32'(10 * BIT_CLKS + BIT_CLKS / 2));
        end
        if (e.isRead) checkOutput("masterNack", 32'(masterNack), 32'd1);
        @(negedge clk);
        checkOutput("donePulseWidth", 32'(done), 32'd0);
        checkOutput("ackErrHold", 32'(ackErr), 32'(e.ackErr));
    endtask

    initial begin
        int n;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstAckErr", 32'(ackErr), 32'd0);
        checkOutput("rstDout", 32'(dout), 32'd0);
        checkOutput("rstScl", 32'(scl), 32'd1);
        checkOutput("rstSda", 32'(sda), 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] write 0x55 <- 0x2F");
        pushExpected(8'hAA, 8'h2F, 2, 1'b0, 8'h00, 10000, 1'b0);
        applyStimulus(7'h55, 1'b0, 8'h2F, 1'b1, 1'b1, 8'h00, 1'b0);

        $display("[TB] read 0x55 -> 0xA5");
        pushExpected(8'hAB, 8'hA5, 2, 1'b0, 8'hA5, 10000, 1'b1);
        applyStimulus(7'h55, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0);

        $display("[TB] write to absent slave");
        pushExpected(8'h78, 8'h00, 1, 1'b1, 8'hA5, 5500, 1'b0);
        applyStimulus(7'h3C, 1'b0, 8'h81, 1'b0, 1'b1, 8'h00, 1'b0);

        $display("[TB] data NACK with dataValid held, then ACKed retry");
        pushExpected(8'h42, 8'hC3, 2, 1'b1, 8'hA5, 10000, 1'b0);
        applyStimulus(7'h21, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b1);
        pushExpected(8'h42, 8'hC3, 2, 1'b0, 8'hA5, 10000, 1'b0);
        applyStimulus(7'h21, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0);
        checkOutput("sclMinPeriod", 32'(minGap >= time'(BIT_CLKS * CLK_PERIOD)), 32'd1);

        $display("[TB] reset during address bit 3");
        addrAckEn = 1'b1; dataAckEn = 1'b1;
        addr = 7'h55; rw = 1'b0; din = 8'h2F; dataValid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 10);
        dataValid = 1'b0;
        repeat (2200) @(negedge clk);
        checkOutput("preRstSda", 32'(sda), 32'd0);
        checkOutput("preRstScl", 32'(scl), 32'd0);
        #3 rst = 1'b0;
        #1;
        checkOutput("midRstScl", 32'(scl), 32'd1);
        checkOutput("midRstSda", 32'(sda), 32'd1);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDout", 32'(dout), 32'd0);
        lastRiseValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] write after reset");
        pushExpected(8'hAA, 8'h2F, 2, 1'b0, 8'h00, 10000, 1'b0);
        applyStimulus(7'h55, 1'b0, 8'h2F, 1'b1, 1'b1, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
